// File: rtl/rs_key_sched.sv
// rtl/rs_key_sched.sv - Twofish RS key-schedule front end producing S0/S1; optional RS_UNROLL2_EN (two RS steps per cycle)
module rs_key_sched (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] key_i,
  input  logic         key_valid_i,
  output logic         key_ready_o,
  output logic [31:0]  s0_o,
  output logic [31:0]  s1_o,
  output logic         s_valid_o
);

`ifdef RS_UNROLL2_EN
  localparam int CW = 2;
  localparam logic [CW-1:0] CNT_MID  = 2'd1;
  localparam logic [CW-1:0] CNT_LAST = 2'd3;
`else
  localparam int CW = 3;
  localparam logic [CW-1:0] CNT_MID  = 3'd3;
  localparam logic [CW-1:0] CNT_LAST = 3'd7;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    W0   = 2'd1,
    W1   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [31:0]   r_q;
  logic [31:0]   k_even0_q, k_even1_q, k_odd1_q;
  logic          accept, word_done;
  logic [31:0]   k_even, step_r, step_x;

  // One RS remainder step: multiply by x modulo the RS generator over GF(2^8)/0x14D
  function automatic logic [31:0] rs_rem(input logic [31:0] r);
    logic [7:0] b, g2, g3;
    b  = r[31:24];
    g2 = {b[6:0], 1'b0} ^ (b[7] ? 8'h4D : 8'h00);
    g3 = {1'b0, b[7:1]} ^ (b[0] ? 8'hA6 : 8'h00) ^ g2;
    return {r[23:0], 8'h00} ^ {g3, g2, g3, b};
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and handshake decode
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    word_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_valid_i) begin
          accept  = 1'b1;
          state_d = W0;
        end
      end
      W0: begin
        if (cnt_q == CNT_LAST) begin
          word_done = 1'b1;
          state_d   = W1;
        end
      end
      W1: begin
        if (cnt_q == CNT_LAST) begin
          word_done = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // RS step datapath; the even word is folded in halfway through each word
  always_comb begin
    k_even = (state_q == W0) ? k_even0_q : k_even1_q;
`ifdef RS_UNROLL2_EN
    step_r = rs_rem(rs_rem(r_q));
`else
    step_r = rs_rem(r_q);
`endif
    step_x = step_r ^ ((cnt_q == CNT_MID) ? k_even : 32'h0);
  end

  // Key capture, remainder register, step counter and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      r_q       <= 32'h0;
      k_even0_q <= 32'h0;
      k_even1_q <= 32'h0;
      k_odd1_q  <= 32'h0;
      s0_o      <= 32'h0;
      s1_o      <= 32'h0;
      s_valid_o <= 1'b0;
    end else if (accept) begin
      k_even0_q <= key_i[31:0];
      k_even1_q <= key_i[95:64];
      k_odd1_q  <= key_i[127:96];
      r_q       <= key_i[63:32];
      cnt_q     <= '0;
      s_valid_o <= 1'b0;
    end else if (state_q != IDLE) begin
      cnt_q <= cnt_q + 1'b1;
      if (word_done && state_q == W0) begin
        s0_o <= step_x;
        r_q  <= k_odd1_q;
      end else if (word_done) begin
        s1_o      <= step_x;
        s_valid_o <= 1'b1;
      end else begin
        r_q <= step_x;
      end
    end
  end

  assign key_ready_o = (state_q == IDLE);

endmodule

// File: tb/tb_rs_key_sched.sv
// tb/tb_rs_key_sched.sv - scoreboard testbench for rs_key_sched
module tb_rs_key_sched;

`ifdef RS_UNROLL2_EN
  localparam int LAT = 8;
`else
  localparam int LAT = 16;
`endif

  localparam logic [7:0] RS_M [4][8] = '{
    '{8'h01, 8'hA4, 8'h55, 8'h87, 8'h5A, 8'h58, 8'hDB, 8'h9E},
    '{8'hA4, 8'h56, 8'h82, 8'hF3, 8'h1E, 8'hC6, 8'h68, 8'hE5},
    '{8'h02, 8'hA1, 8'hFC, 8'hC1, 8'h47, 8'hAE, 8'h3D, 8'h19},
    '{8'hA4, 8'h55, 8'h87, 8'h5A, 8'h58, 8'hDB, 8'h9E, 8'h03}
  };

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] key_i;
  logic         key_valid_i;
  logic         key_ready_o;
  logic [31:0]  s0_o, s1_o;
  logic         s_valid_o;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic        prev_valid = 1'b0;
  logic [63:0] mon_e;

  rs_key_sched dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_i       (key_i),
    .key_valid_i (key_valid_i),
    .key_ready_o (key_ready_o),
    .s0_o        (s0_o),
    .s1_o        (s1_o),
    .s_valid_o   (s_valid_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h4D) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [31:0] rs_word(input logic [63:0] m);
    logic [31:0] w;
    logic [7:0]  acc;
    for (int i = 0; i < 4; i++) begin
      acc = 8'h00;
      for (int j = 0; j < 8; j++) acc = acc ^ gmul(RS_M[i][j], m[8*j +: 8]);
      w[8*i +: 8] = acc;
    end
    return w;
  endfunction

  function automatic logic [63:0] model(input logic [127:0] k);
    return {rs_word(k[63:0]), rs_word(k[127:64])};
  endfunction

  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Scoreboard: compare on each rising edge of s_valid_o
  always @(posedge clk) begin
    #1;
    if (s_valid_o && !prev_valid) begin
      check("sb_nonempty", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("s0", 64'(s0_o), 64'(mon_e[63:32]));
        check("s1", 64'(s1_o), 64'(mon_e[31:0]));
      end
    end
    prev_valid = s_valid_o;
  end

  // Entered at posedge+1 with the block idle; returns at posedge+1 after the result
  task automatic run_key(input logic [127:0] k);
    int   n;
    logic rdy_low;
    logic [63:0] e;
    e = model(k);
    check("ready_before", 64'(key_ready_o), 64'd1);
    key_i       = k;
    key_valid_i = 1'b1;
    @(posedge clk); #1;
    key_valid_i = 1'b0;
    exp_q.push_back(e);
    n       = 0;
    rdy_low = 1'b1;
    while (!s_valid_o && n < 100) begin
      if (key_ready_o) rdy_low = 1'b0;
      if (n == LAT / 2) check("s0_early", 64'(s0_o), 64'(e[63:32]));
      key_i = rand_key();
      @(posedge clk); #1;
      n++;
    end
    check("latency", 64'(n), 64'(LAT));
    check("ready_low", 64'(rdy_low), 64'd1);
    check("ready_after", 64'(key_ready_o), 64'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] ka, kb;
    int n;
    rst_n       = 1'b0;
    key_valid_i = 1'b0;
    key_i       = 128'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 64'(key_ready_o), 64'd1);
    check("rst_valid", 64'(s_valid_o), 64'd0);
    check("rst_s0", 64'(s0_o), 64'd0);
    check("rst_s1", 64'(s1_o), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_key(128'h0);
    check("zero_s0", 64'(s0_o), 64'h0);
    check("zero_s1", 64'(s1_o), 64'h0);
    run_key(128'h1);
    check("m0_s0", 64'(s0_o), 64'hA402A401);
    check("m0_s1", 64'(s1_o), 64'h0);
    run_key(128'h01 << 56);
    check("m7_s0", 64'(s0_o), 64'h0319E59E);
    check("m7_s1", 64'(s1_o), 64'h0);
    run_key(128'h01 << 64);
    check("m8_s0", 64'(s0_o), 64'h0);
    check("m8_s1", 64'(s1_o), 64'hA402A401);

    for (int i = 0; i < 1000; i++) run_key(rand_key());

    // Back-to-back with key_valid_i held high
    ka = rand_key();
    kb = rand_key();
    key_i       = ka;
    key_valid_i = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back(model(ka));
    key_i = kb;
    n = 0;
    while (!s_valid_o && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("b2b_latency", 64'(n), 64'(LAT));
    check("b2b_ready_e16", 64'(key_ready_o), 64'd1);
    @(posedge clk); #1;
    check("b2b_accept_e17", 64'(key_ready_o), 64'd0);
    check("b2b_valid_e17", 64'(s_valid_o), 64'd0);
    key_valid_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check("b2b_valid_low", 64'(s_valid_o), 64'd0);
    end
    // Reset at E5 of the second run, with key_valid_i asserted alongside
    rst_n       = 1'b0;
    key_valid_i = 1'b1;
    @(posedge clk); #1;
    check("midrst_s0", 64'(s0_o), 64'd0);
    check("midrst_s1", 64'(s1_o), 64'd0);
    check("midrst_valid", 64'(s_valid_o), 64'd0);
    check("midrst_ready", 64'(key_ready_o), 64'd1);
    @(posedge clk); #1;
    check("rst_beats_valid", 64'(key_ready_o), 64'd1);
    rst_n       = 1'b1;
    key_valid_i = 1'b0;
    @(posedge clk); #1;
    check("post_rst_valid", 64'(s_valid_o), 64'd0);
    run_key(128'h1);
    check("recover_s0", 64'(s0_o), 64'hA402A401);

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rs_key_sched.md
Name: rs_key_sched

Overview:
- Twofish key-schedule front end. Computes the two key-dependent S-box words S0 and S1 from a 128-bit user key, using the Reed-Solomon (RS) code over GF(2^8).
- Producer for the s-box stage: s0_o and s1_o connect directly to the s0/s1 inputs of the sBox/ssBox g-function path.
- Iterative: one RS remainder step per cycle. A new key is accepted through a valid/ready handshake.

Parameters:
- none (key length fixed at 128 bits, k=2)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous active-low reset
- key_i  input  128  user key; byte m[j] = key_i[8j+7:8j], j=0..15
- key_valid_i  input  1  key_i is valid
- key_ready_o  output  1  block can accept a key (high in IDLE only)
- s0_o  output  32  S0 = RS(m0..m7); byte b of S0 = s0_o[8b+7:8b]
- s1_o  output  32  S1 = RS(m8..m15)
- s_valid_o  output  1  s0_o/s1_o hold the result for the last accepted key

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset values: key_ready_o=1, s_valid_o=0, s0_o=0, s1_o=0, FSM=IDLE, step counter=0.
- Accept: key_valid_i && key_ready_o on a rising edge.
  - key_i is registered, s_valid_o clears, FSM enters W0.
  - key_i is ignored after accept. key_valid_i is ignored while not IDLE.
- Word split: k_even0={m3,m2,m1,m0}, k_odd0={m7,m6,m5,m4}; k_even1={m11..m8}, k_odd1={m15..m12}.
- RS_rem(x) on 32-bit r:
  - b=r[31:24]
  - g2=((b<<1) ^ (b[7] ? 8'h4D : 0)) & 8'hFF (field poly 0x14D)
  - g3=(b>>1) ^ (b[0] ? 8'hA6 : 0) ^ g2
  - r_next=(r<<8) ^ {g3,g2,g3,b}
- Per word (8 steps):
  - Load r=k_odd.
  - Steps 1-4: r=RS_rem(r).
  - After step 4, r^=k_even (combined into the step-4 register update).
  - Steps 5-8: r=RS_rem(r).
  - Result is r.
- FSM:
  - IDLE -> W0 on accept.
  - W0: 8 steps on word pair 0. On the 8th step, s0_o<=r, r<=k_odd1, go to W1.
  - W1: 8 steps. On the 8th step, s1_o<=r, s_valid_o<=1, go to IDLE.
- Step counter: 3 bits, wraps 7->0 at each word boundary.
- Latency: accept at edge E0 -> s_valid_o=1 and both words valid after edge E16. key_ready_o is low for cycles E0..E15 and high again after E16. Minimum key-to-key period is 17 cycles.
- Output hold:
  - s0_o/s1_o keep their values until overwritten by the next computation.
  - s0_o updates at E8, while s_valid_o is still 0. Consumers must gate on s_valid_o.
  - s_valid_o stays high until the next accept.
- Boundary conditions:
  - Back-to-back key_valid_i held high: the next key is accepted at the first edge with key_ready_o=1 (E16 edge sees IDLE only after transition, so accept at E17).
  - rst_n low mid-computation: next edge returns to reset values; the partial result is discarded.
  - key_valid_i and rst_n low in the same cycle: reset wins.
- Arithmetic: all GF ops are XOR/shift. No carries; all widths exactly 8/32.

Optional Feature:
- Macro: RS_UNROLL2_EN.
- Defined: two cascaded RS_rem operations per cycle. The k_even XOR is applied after the second step of cycle 2. 4 cycles per word; accept at E0 -> s_valid_o after E8; s0_o updates at E4. Step counter is 2 bits.
- Undefined: one step per cycle, 16-cycle latency as above.
- Results are bit-identical in both builds.

Test Plan:
- Reset, then key_i=0 accept -> after 16 cycles s_valid_o=1, s0_o=32'h0, s1_o=32'h0; key_ready_o low exactly cycles E0..E15.
- key_i with m0=8'h01 only -> s0_o=32'hA402A401, s1_o=32'h0.
- key_i with m7=8'h01 only -> s0_o=32'h0319E59E, s1_o=32'h0; then m8=8'h01 only -> s0_o=0, s1_o=32'hA402A401.
- Random keys (1000) vs reference model of the 4x8 RS matrix (rows 01 A4 55 87 5A 58 DB 9E / A4 56 82 F3 1E C6 68 E5 / 02 A1 FC C1 47 AE 3D 19 / A4 55 87 5A 58 DB 9E 03) -> exact match. key_i is changed every cycle after accept to prove it is captured once.
- key_valid_i held high across two keys -> second accept at E17, s_valid_o low E17..E32. Pulse rst_n low at E5 of the second run -> outputs zero, key_ready_o=1 next cycle.
- RS_UNROLL2_EN build: rerun the three vectors above -> same values, s_valid_o after E8.
